// File: rtl/cipher_core_iter.sv
// Iterative XOR/rotate block cipher, one round per cycle; CIPHER_PARITY_EN adds out_parity.
// Latency ROUNDS+1 cycles accept-to-out_valid; result held in DONE until out_ready, no accept while busy.
module cipher_core_iter #(
    parameter int DATA_W = 256,
    parameter int KEY_W  = 64,
    parameter int ROUNDS = 8,
    parameter int ROT    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEY_W-1:0]  key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
`ifdef CIPHER_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    localparam int CNT_W = $clog2(ROUNDS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic                mode_q, mode_d;

    logic [CNT_W-1:0]    rnd_idx;
    logic [31:0]         rk_amt;
    logic [2*KEY_W-1:0]  key_dbl;
    logic [KEY_W-1:0]    key_rot;
    logic [DATA_W-1:0]   rk_full;
    logic [DATA_W-1:0]   enc_x;
    logic [DATA_W-1:0]   enc_next;
    logic [DATA_W-1:0]   dec_next;

    // The counter runs ROUNDS..1, so the round index depends on direction.
    assign rnd_idx  = mode_q ? (cnt_q - CNT_W'(1)) : (CNT_W'(ROUNDS) - cnt_q);
    assign rk_amt   = 32'(rnd_idx) % KEY_W;
    assign key_dbl  = {key_q, key_q} << rk_amt;
    assign key_rot  = key_dbl[2*KEY_W-1:KEY_W];
    assign rk_full  = {(DATA_W / KEY_W){key_rot}};

    assign enc_x    = data_q ^ rk_full;
    assign enc_next = {enc_x[DATA_W-1-ROT:0], enc_x[DATA_W-1:DATA_W-ROT]};
    assign dec_next = {data_q[ROT-1:0], data_q[DATA_W-1:ROT]} ^ rk_full;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        key_d   = key_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    key_d   = key;
                    mode_d  = mode;
                    cnt_d   = CNT_W'(ROUNDS);
                    state_d = RUN;
                end
            end
            RUN: begin
                // Extra RUN cycle at cnt==0 makes the accept-to-valid latency ROUNDS+1.
                if (cnt_q != '0) begin
                    data_d = mode_q ? dec_next : enc_next;
                    cnt_d  = cnt_q - CNT_W'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            key_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign out_data  = data_q;

`ifdef CIPHER_PARITY_EN
    assign out_parity = ^data_q;
`endif

endmodule

// File: tb/tb_cipher_core_iter.sv
// Bench for cipher_core_iter: default core under random traffic against a cycle-level model, plus a ROUNDS=1 core for literal vectors.
module tb_cipher_core_iter;

    localparam int DW = 256;
    localparam int KW = 64;
    localparam int NR = 8;
    localparam int RT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter core
    logic          rst, iv, ir, md, ov, ordy, bsy;
    logic [DW-1:0] idat, odat;
    logic [KW-1:0] ky;
    // ROUNDS=1 core
    logic          rst1, iv1, ir1, md1, ov1, ordy1, bsy1;
    logic [DW-1:0] idat1, odat1;
    logic [KW-1:0] ky1;
`ifdef CIPHER_PARITY_EN
    logic          par, par1;
`endif

    cipher_core_iter u0 (
        .clk(clk), .reset(rst), .in_valid(iv), .in_ready(ir), .mode(md),
        .in_data(idat), .key(ky), .out_valid(ov), .out_ready(ordy),
        .out_data(odat), .busy(bsy)
`ifdef CIPHER_PARITY_EN
        , .out_parity(par)
`endif
    );

    cipher_core_iter #(.DATA_W(256), .KEY_W(64), .ROUNDS(1), .ROT(3)) u1 (
        .clk(clk), .reset(rst1), .in_valid(iv1), .in_ready(ir1), .mode(md1),
        .in_data(idat1), .key(ky1), .out_valid(ov1), .out_ready(ordy1),
        .out_data(odat1), .busy(bsy1)
`ifdef CIPHER_PARITY_EN
        , .out_parity(par1)
`endif
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Reference cipher: straight from the round definitions.
    function automatic logic [DW-1:0] mdl(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                          input logic dec, input int rounds);
        logic [DW-1:0] s;
        logic [KW-1:0] rk;
        logic [DW-1:0] kf;
        int r;
        int a;
        s = d;
        for (int i = 0; i < rounds; i++) begin
            r  = dec ? (rounds - 1 - i) : i;
            a  = r % KW;
            rk = (a == 0) ? k : ((k << a) | (k >> (KW - a)));
            kf = {(DW / KW){rk}};
            if (!dec) begin
                s = s ^ kf;
                s = (s << RT) | (s >> (DW - RT));
            end else begin
                s = (s >> RT) | (s << (DW - RT));
                s = s ^ kf;
            end
        end
        return s;
    endfunction

    // Transaction-level model of u0: result due ROUNDS+1 edges after accept, held until consumed.
    bit            m_busy = 1'b0;
    int            m_cnt  = 0;
    logic [DW-1:0] m_exp  = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_cnt  = 0;
        end else if (!m_busy) begin
            if (iv) begin
                m_busy = 1'b1;
                m_cnt  = NR + 1;
                m_exp  = mdl(idat, ky, md, NR);
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
        end else if (ordy) begin
            m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", ir, !m_busy);
            chk("busy", bsy, m_busy);
            chk("out_valid", ov, (m_busy && m_cnt == 0));
            if (m_busy && m_cnt == 0) begin
                chk("out_data", odat, m_exp);
`ifdef CIPHER_PARITY_EN
                chk("out_parity", par, ^m_exp);
`endif
            end
        end
    end

    task automatic start0(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic m);
        iv = 1'b1; idat = d; ky = k; md = m;
        @(posedge clk); #1;
        iv = 1'b0;
    endtask

    task automatic wait_ov0(output int lat);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ov) break;
        end
        if (!ov) begin
            total++; bad++;
            $display("FAIL u0_timeout got=no_out_valid exp=out_valid");
        end
    endtask

    task automatic consume0();
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
    endtask

    task automatic req1(input logic [DW-1:0] d, input logic [KW-1:0] k, output logic [DW-1:0] res,
                        output int lat);
        iv1 = 1'b1; idat1 = d; ky1 = k; md1 = 1'b0;
        @(posedge clk); #1;
        iv1 = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (ov1) break;
        end
        if (!ov1) begin
            total++; bad++;
            $display("FAIL u1_timeout got=no_out_valid exp=out_valid");
        end
        res = odat1;
`ifdef CIPHER_PARITY_EN
        chk("v1_parity", par1, ^odat1);
`endif
        ordy1 = 1'b1;
        @(posedge clk); #1;
        ordy1 = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] res, res2, held, top, vec1;
        int lat;
        vec1 = {64'h78, 64'h78, 64'h78, 64'hD8};
        top  = '0;
        top[DW-1] = 1'b1;

        rst = 1'b1; iv = 1'b0; md = 1'b0; idat = '0; ky = '0; ordy = 1'b0;
        rst1 = 1'b1; iv1 = 1'b0; md1 = 1'b0; idat1 = '0; ky1 = '0; ordy1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; rst1 = 1'b0;
        chk_en = 1'b1;

        // Pin the model with hand-computed values
        chk("mdl_vec1", mdl(DW'(20), KW'(15), 1'b0, 1), vec1);
        chk("mdl_wrap", mdl(top, '0, 1'b0, 1), DW'(4));
        chk("mdl_roundtrip", mdl(mdl(DW'(20), KW'(15), 1'b0, NR), KW'(15), 1'b1, NR), DW'(20));

        // Reset state
        @(negedge clk);
        chk("rst_in_ready", ir, 1'b1);
        chk("rst_out_valid", ov, 1'b0);
        chk("rst_busy", bsy, 1'b0);
        chk("rst_data", odat, '0);
        #1;

        // Single-round vector and rotation wrap on the ROUNDS=1 core
        req1(DW'(20), KW'(15), res, lat);
        chk("v1_latency", lat, 2);
        chk("v1_data", res, vec1);
`ifdef CIPHER_PARITY_EN
        chk("v1_parity_lit", ^res, 1'b0);
`endif
        req1(top, '0, res, lat);
        chk("wrap_data", res, DW'(4));

        // Round trip on the default core
        @(posedge clk); #1;
        start0(DW'(20), KW'(15), 1'b0);
        wait_ov0(lat);
        chk("rt_enc_latency", lat, 9);
        res = odat;
        consume0();
        start0(res, KW'(15), 1'b1);
        wait_ov0(lat);
        chk("rt_dec_latency", lat, 9);
        chk("rt_dec_data", odat, DW'(20));
        consume0();

        // Backpressure: hold in DONE with noisy inputs
        start0({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom}, 1'b0);
        wait_ov0(lat);
        held = odat;
        for (int i = 0; i < 5; i++) begin
            iv = 1'($urandom);
            idat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            md = 1'($urandom);
            @(posedge clk); #1;
            chk("bp_stable", odat, held);
            chk("bp_in_ready", ir, 1'b0);
            chk("bp_out_valid", ov, 1'b1);
        end
        iv = 1'b0;
        consume0();
        chk("bp_idle_ready", ir, 1'b1);
        chk("bp_idle_valid", ov, 1'b0);

        // Reset in the middle of a run
        start0(DW'(20), KW'(15), 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", ov, 1'b0);
        chk("mid_rst_busy", bsy, 1'b0);
        chk("mid_rst_ready", ir, 1'b1);
        repeat (15) @(posedge clk);
        #1;
        start0(DW'(20), KW'(15), 1'b0);
        wait_ov0(lat);
        chk("post_rst_latency", lat, 9);
        chk("post_rst_data", odat, mdl(DW'(20), KW'(15), 1'b0, NR));
        consume0();

        // Random traffic with random consumer stalls
        for (int t = 0; t < 30; t++) begin
            res2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            start0(res2, {$urandom, $urandom}, 1'($urandom));
            wait_ov0(lat);
            repeat ($urandom_range(0, 3)) begin
                iv = 1'($urandom);
                idat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                @(posedge clk); #1;
            end
            iv = 1'b0;
            consume0();
        end

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cipher_core_iter.md
CIPHER_CORE_ITER -- requirements
Module: cipher_core_iter

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 256, block width in bits; must be a multiple of KEY_W.
- KEY_W, 64, key width in bits.
- ROUNDS, 8, round count; must be 1 or more.
- ROT, 3, per-round left-rotate amount; must satisfy 0 < ROT < DATA_W.
REQ-002 Ports SHALL be:
- clk, in, 1, sole clock; all state on rising edge.
- reset, in, 1, synchronous, active-high.
- in_valid, in, 1, request present.
- in_ready, out, 1, core can accept a request.
- mode, in, 1, 0 = encrypt, 1 = decrypt.
- in_data, in, DATA_W, plaintext or ciphertext block.
- key, in, KEY_W, cipher key.
- out_valid, out, 1, result present.
- out_ready, in, 1, consumer accepts the result.
- out_data, out, DATA_W, result block.
- busy, out, 1, high in RUN or DONE.
REQ-003 The clock SHALL be the single clock clk; reset SHALL be synchronous and active-high.

Function
REQ-004 Round key r (r = 0..ROUNDS-1) SHALL be DATA_W/KEY_W concatenated copies of key rotated left by (r mod KEY_W) bits within KEY_W.
REQ-005 An encrypt round r SHALL compute state = rotl_DATA_W(state XOR K_r, ROT), with rounds applied in order r = 0..ROUNDS-1.
REQ-006 A decrypt round SHALL compute state = rotr_DATA_W(state, ROT) XOR K_r, with rounds applied in order r = ROUNDS-1 down to 0, so decrypt exactly inverts encrypt.
REQ-007 The FSM SHALL have states IDLE, RUN and DONE.
REQ-008 In IDLE, in_ready SHALL be 1; on in_valid=1 the core SHALL latch in_data, key and mode, load the round counter, and move to RUN.
REQ-009 RUN SHALL perform exactly one round per cycle for ROUNDS cycles, then move to DONE.
REQ-010 In DONE, out_valid SHALL be 1 and out_data SHALL hold the final state.
REQ-011 Latency SHALL be ROUNDS+1 cycles from the accept edge to the first cycle with out_valid=1.
REQ-012 In DONE with out_ready=0, out_valid and out_data SHALL hold stable indefinitely.
REQ-013 In DONE with out_ready=1, the core SHALL move to IDLE on that edge; a new request is accepted no earlier than the next cycle.
REQ-014 in_ready SHALL be 0 in RUN and DONE; in_valid, in_data, key and mode changes in those states SHALL be ignored.
REQ-015 out_valid SHALL be 0 in IDLE and RUN; out_data SHALL be don't-care outside DONE.
REQ-016 The round counter SHALL be $clog2(ROUNDS+1) bits wide and SHALL never wrap during a run.
REQ-017 Rotation SHALL be modulo DATA_W, with bits rotated out re-entering at the opposite end and no bits lost.

Reset
REQ-018 While reset=1 at a clock edge, the FSM SHALL go to IDLE, the state register and counter SHALL clear to 0, out_valid and busy SHALL be 0, and in_ready SHALL be 1 from the following cycle.
REQ-019 Reset asserted mid-RUN or in DONE SHALL discard the operation; no out_valid pulse SHALL follow.

Configuration
REQ-020 With macro CIPHER_PARITY_EN defined, the core SHALL add output out_parity (1 bit), equal to the XOR-reduction of out_data and valid whenever out_valid=1.
REQ-021 With CIPHER_PARITY_EN undefined, the out_parity port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-022 Single-round vector: ROUNDS=1, DATA_W=256, KEY_W=64, ROT=3, mode=0, in_data=20, key=15 -> out_data = three upper 64-bit words 0x78 each, low word 0xD8, out_valid 2 cycles after accept.
REQ-023 Round trip: defaults, in_data=20, key=15, encrypt, then feed the result back with mode=1 -> out_data=20; each request gives out_valid exactly 9 cycles after accept.
REQ-024 Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and in_data -> out_data stable, in_ready=0, nothing accepted; out_ready=1 -> IDLE the next cycle.
REQ-025 Reset mid-run: assert reset at RUN round 4 -> the next cycle shows IDLE, out_valid=0, busy=0; no late result appears; a subsequent request completes normally.
REQ-026 Rotation wrap: in_data with only bit DATA_W-1 set, key=0, ROUNDS=1, encrypt -> out_data = 4 (bits wrap to the low end).
REQ-027 With CIPHER_PARITY_EN defined, the REQ-022 vector -> out_parity = XOR-reduction of that out_data = 0 (each 0x78 word has 4 set bits, 0xD8 has 4 set bits, 16 total).
